stream_ingress_fifo: RTL and testbench
======================================

# stream_ingress_fifo

Ingress buffer between the inbound network stream and the CGRA data path's column-0 PE input. Accepts phit beats with per-lane valid masks through a ready/valid handshake and buffers them in a DEPTH-entry circular FIFO. Presents the head entry first-word-fall-through as `FIFO_out_tdata`/`FIFO_out_tvalid`, which the data path's first input mux consumes. Pops are driven by the column controller's `rd_en`.

## Interface
- `phit_size`, 512: data width of one beat (SIMD_degree × float lanes).
- `SIMD_degree`, 16: number of lanes; one valid bit per lane.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `AF_LEVEL`, DEPTH-2: `almost_full` threshold, 1..DEPTH.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `flush` input 1: synchronous clear of contents.
- `stream_in` input phit_size: inbound beat data.
- `tvalid_stream_in` input SIMD_degree: per-lane valid; the beat is offered when any bit is 1.
- `tready_stream_in` output 1: FIFO can accept a beat this cycle.
- `FIFO_out_tdata` output phit_size: head entry data; 0 when empty.
- `FIFO_out_tvalid` output SIMD_degree: head entry lane mask; 0 when empty.
- `rd_en` input 1: pop the head entry at this edge.
- `count` output $clog2(DEPTH)+1: occupancy.
- `empty`, `full`, `almost_full` output 1: `count==0`, `count==DEPTH`, `count>=AF_LEVEL`.
- `err_underflow` output 1: sticky; set by `rd_en` while empty.

## Operation
- Storage: DEPTH × (SIMD_degree+phit_size) array, plus `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits.
- Pointers wrap modulo DEPTH naturally. `count` is a separate register and disambiguates full from empty.
- **Push** = `(|tvalid_stream_in) & tready_stream_in & !flush`. On push, write {mask, data} at `wr_ptr` and increment `wr_ptr`.
- An all-zero mask is not a beat: it is never stored and does not move pointers.
- `tready_stream_in = !full & !flush`. It is combinational from registers and `flush` only, never from `tvalid_stream_in`.
- The upstream source holds data and mask stable while ready is low (standard AXI-stream). No beat is ever dropped.
- **Pop** = `rd_en & !empty`. On pop, increment `rd_ptr`.
- **Underflow:** `rd_en & empty` sets `err_underflow`, which stays set until `rst` or `flush`. Pointers are unchanged.
- **Simultaneous push and pop** (non-empty, non-full): both pointers advance and `count` is unchanged.
- Push while full is impossible because ready is low. Pop while full is legal and frees one slot for the next cycle; there is no same-cycle pass-through.
- Push while empty: the new entry becomes visible next cycle.
- **Flush:** next edge sets pointers, `count`, and `err_underflow` to 0. It overrides any push or pop in the same cycle. Array contents are don't-care.
- **Outputs:**
  - `FIFO_out_tdata` = `mem[rd_ptr].data` when `!empty`, else 0.
  - `FIFO_out_tvalid` = `mem[rd_ptr].mask` when `!empty`, else 0.
  - Both are combinational from registered state only.
- **Reset:**
  - `rst` high clears pointers, `count`, and `err_underflow` immediately (asynchronous).
  - Outputs during reset: `FIFO_out_tdata`=0, `FIFO_out_tvalid`=0, `tready_stream_in`=1 if `!flush`, `count`=0, `empty`=1, `full`=0, `almost_full`=0, `err_underflow`=0.
  - Reset asserted mid-transfer discards all content. Release is synchronous to `clk` externally.

## Timing
- Write latency: push at edge N → entry on `FIFO_out_*` and `count` updated in cycle N+1 (1 cycle).
- Pop at edge N → next entry, or zeros if now empty, shown in cycle N+1.
- Sustained throughput: 1 beat/cycle in and out with push and pop every cycle.
- Flags and `count` update on the same edge as the pointer change.
- `tready_stream_in` drops in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from full.
- No combinational path from `rd_en` or `tvalid_stream_in` to any output.

## Test plan
Configuration for all cases: phit_size=64, SIMD_degree=2, DEPTH=4, AF_LEVEL=3.

- **Reset values:** apply `rst` mid-cycle with 2 entries stored → outputs 0 and `empty`=1 immediately, before any clock edge; `tready_stream_in`=1.
- **Fill, stall, drain:** push 0xA0..0xA3 with mask 2'b11 → `almost_full` after the 3rd, `full` and ready=0 after the 4th. Hold 0xA4 valid for 3 cycles → not accepted. Pop 5 times → 0xA0, 0xA1, 0xA2, 0xA3, 0xA4 in order, no loss.
- **Partial and zero masks:** push data 0x11 mask 2'b01, then mask 2'b00, then 0x22 mask 2'b10 → `count`=2. Head shows 0x11/2'b01, then 0x22/2'b10.
- **Concurrent push/pop at count=2 for 8 cycles:** `count` stays 2. Outputs follow push order with 2-entry lag. Pointers wrap twice with no corruption.
- **Underflow:** `rd_en` while empty → `err_underflow`=1 next cycle and stays 1 through subsequent pushes; `flush` clears it.
- **Flush precedence:** at count=3, `flush` together with a valid push and `rd_en` → next cycle `count`=0, `empty`=1. The pushed beat is not stored, and ready was 0 during the flush cycle.

Source files
------------

// File: rtl/stream_ingress_fifo.sv
// stream_ingress_fifo: ingress FIFO between the inbound phit stream and the
// column-0 PE input. It stores {lane mask, data} beats in a circular buffer and
// presents the head entry first-word-fall-through. It accepts one beat per cycle
// and pops one beat per cycle.
module stream_ingress_fifo #(
  parameter int phit_size   = 512,
  parameter int SIMD_degree = 16,
  parameter int DEPTH       = 16,
  parameter int AF_LEVEL    = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [phit_size-1:0]       stream_in,
  input  logic [SIMD_degree-1:0]     tvalid_stream_in,
  output logic                       tready_stream_in,
  output logic [phit_size-1:0]       FIFO_out_tdata,
  output logic [SIMD_degree-1:0]     FIFO_out_tvalid,
  input  logic                       rd_en,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       err_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Data storage is not reset; only the pointers and count say what is valid.
  logic [phit_size-1:0]   r_mem_data [DEPTH];
  logic [SIMD_degree-1:0] r_mem_mask [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_err_underflow;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // Ready depends only on registered state and flush, never on tvalid.
  assign tready_stream_in = !w_full && !flush;

  // An all-zero lane mask is not a beat, so it never reaches storage.
  assign w_push = (|tvalid_stream_in) && tready_stream_in;
  assign w_pop  = rd_en && !w_empty && !flush;

  // Write the incoming beat into the slot under the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= stream_in;
      r_mem_mask[r_wr_ptr] <= tvalid_stream_in;
    end
  end

  // Control state: pointers, occupancy and the sticky underflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_err_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (rd_en && w_empty) r_err_underflow <= 1'b1;
    end
  end

  // Head entry shown only while something is stored; zeros otherwise.
  always_comb begin
    FIFO_out_tdata  = '0;
    FIFO_out_tvalid = '0;
    if (!w_empty) begin
      FIFO_out_tdata  = r_mem_data[r_rd_ptr];
      FIFO_out_tvalid = r_mem_mask[r_rd_ptr];
    end
  end

  assign count         = r_count;
  assign empty         = w_empty;
  assign full          = w_full;
  assign almost_full   = (r_count >= CW'(AF_LEVEL));
  assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_stream_ingress_fifo.sv
// Directed bench for stream_ingress_fifo (64-bit beats, 2 lanes, depth 4, AF at 3).
module tb_stream_ingress_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [63:0] stream_in = '0;
  logic [1:0]  tvalid_stream_in = '0;
  logic        tready_stream_in;
  logic [63:0] FIFO_out_tdata;
  logic [1:0]  FIFO_out_tvalid;
  logic        rd_en = 1'b0;
  logic [2:0]  count;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic        err_underflow;

  int n_vec = 0;
  int n_err = 0;

  stream_ingress_fifo #(
    .phit_size(64), .SIMD_degree(2), .DEPTH(4), .AF_LEVEL(3)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .stream_in(stream_in), .tvalid_stream_in(tvalid_stream_in),
    .tready_stream_in(tready_stream_in),
    .FIFO_out_tdata(FIFO_out_tdata), .FIFO_out_tvalid(FIFO_out_tvalid),
    .rd_en(rd_en), .count(count), .empty(empty), .full(full),
    .almost_full(almost_full), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Outputs while reset is held from time zero.
    #2;
    n_vec++; if (empty !== 1'b1 || count !== 3'd0 || full !== 1'b0 || almost_full !== 1'b0) begin
      n_err++; $display("FAIL reset_hold_flags: empty=%b count=%0d full=%b af=%b, want 1/0/0/0", empty, count, full, almost_full); end
    @(negedge clk); rst = 1'b0;
    step();
    // Store two entries, then assert reset mid-cycle.
    stream_in = 64'h1; tvalid_stream_in = 2'b11; step();
    stream_in = 64'h2; step();
    tvalid_stream_in = 2'b00;
    n_vec++; if (count !== 3'd2 || FIFO_out_tdata !== 64'h1) begin
      n_err++; $display("FAIL reset_prefill: count=%0d head=%h, want 2/1", count, FIFO_out_tdata); end
    #2; rst = 1'b1; #1;
    n_vec++; if (FIFO_out_tdata !== 64'h0 || FIFO_out_tvalid !== 2'b00) begin
      n_err++; $display("FAIL reset_async_out: data=%h mask=%b, want 0/00", FIFO_out_tdata, FIFO_out_tvalid); end
    n_vec++; if (empty !== 1'b1 || count !== 3'd0 || tready_stream_in !== 1'b1 || err_underflow !== 1'b0) begin
      n_err++; $display("FAIL reset_async_flags: empty=%b count=%0d ready=%b err=%b, want 1/0/1/0", empty, count, tready_stream_in, err_underflow); end
    @(negedge clk); rst = 1'b0;
    step();
  endtask

  task automatic test_fill_stall_drain();
    logic [2:0] exp_cnt [5] = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    tvalid_stream_in = 2'b11;
    for (int i = 0; i < 4; i++) begin
      stream_in = 64'hA0 + 64'(i);
      step();
      n_vec++; if (count !== 3'(i + 1) || almost_full !== (i >= 2)) begin
        n_err++; $display("FAIL fill_count_%0d: count=%0d af=%b, want %0d/%b", i, count, almost_full, i + 1, (i >= 2)); end
    end
    n_vec++; if (full !== 1'b1 || tready_stream_in !== 1'b0) begin
      n_err++; $display("FAIL fill_full: full=%b ready=%b, want 1/0", full, tready_stream_in); end
    stream_in = 64'hA4;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (count !== 3'd4 || tready_stream_in !== 1'b0 || FIFO_out_tdata !== 64'hA0) begin
        n_err++; $display("FAIL stall_%0d: count=%0d ready=%b head=%h, want 4/0/a0", i, count, tready_stream_in, FIFO_out_tdata); end
    end
    for (int k = 0; k < 5; k++) begin
      n_vec++; if (FIFO_out_tdata !== 64'hA0 + 64'(k) || FIFO_out_tvalid !== 2'b11) begin
        n_err++; $display("FAIL drain_head_%0d: data=%h mask=%b, want %h/11", k, FIFO_out_tdata, FIFO_out_tvalid, 64'hA0 + 64'(k)); end
      rd_en = 1'b1;
      step();
      if (k == 0) begin
        n_vec++; if (tready_stream_in !== 1'b1) begin
          n_err++; $display("FAIL drain_ready_rise: ready=%b, want 1", tready_stream_in); end
      end
      if (k == 1) tvalid_stream_in = 2'b00;
      n_vec++; if (count !== exp_cnt[k]) begin
        n_err++; $display("FAIL drain_count_%0d: count=%0d, want %0d", k, count, exp_cnt[k]); end
    end
    rd_en = 1'b0;
    n_vec++; if (empty !== 1'b1 || FIFO_out_tdata !== 64'h0) begin
      n_err++; $display("FAIL drain_empty: empty=%b data=%h, want 1/0", empty, FIFO_out_tdata); end
  endtask

  task automatic test_masks();
    stream_in = 64'h11; tvalid_stream_in = 2'b01; step();
    stream_in = 64'h33; tvalid_stream_in = 2'b00; step();
    n_vec++; if (count !== 3'd1) begin
      n_err++; $display("FAIL mask_zero_ignored: count=%0d, want 1", count); end
    stream_in = 64'h22; tvalid_stream_in = 2'b10; step();
    tvalid_stream_in = 2'b00;
    n_vec++; if (count !== 3'd2 || FIFO_out_tdata !== 64'h11 || FIFO_out_tvalid !== 2'b01) begin
      n_err++; $display("FAIL mask_head1: count=%0d data=%h mask=%b, want 2/11/01", count, FIFO_out_tdata, FIFO_out_tvalid); end
    rd_en = 1'b1; step();
    n_vec++; if (count !== 3'd1 || FIFO_out_tdata !== 64'h22 || FIFO_out_tvalid !== 2'b10) begin
      n_err++; $display("FAIL mask_head2: count=%0d data=%h mask=%b, want 1/22/10", count, FIFO_out_tdata, FIFO_out_tvalid); end
    step(); rd_en = 1'b0;
    n_vec++; if (empty !== 1'b1) begin
      n_err++; $display("FAIL mask_drain: empty=%b, want 1", empty); end
  endtask

  task automatic test_back_to_back();
    tvalid_stream_in = 2'b11;
    stream_in = 64'hC0; step();
    stream_in = 64'hC1; step();
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (FIFO_out_tdata !== 64'hC0 + 64'(i)) begin
        n_err++; $display("FAIL b2b_head_%0d: data=%h, want %h", i, FIFO_out_tdata, 64'hC0 + 64'(i)); end
      stream_in = 64'hC2 + 64'(i);
      step();
      n_vec++; if (count !== 3'd2) begin
        n_err++; $display("FAIL b2b_count_%0d: count=%0d, want 2", i, count); end
    end
    tvalid_stream_in = 2'b00;
    n_vec++; if (FIFO_out_tdata !== 64'hC8) begin
      n_err++; $display("FAIL b2b_tail0: data=%h, want c8", FIFO_out_tdata); end
    step();
    n_vec++; if (FIFO_out_tdata !== 64'hC9) begin
      n_err++; $display("FAIL b2b_tail1: data=%h, want c9", FIFO_out_tdata); end
    step(); rd_en = 1'b0;
    n_vec++; if (empty !== 1'b1) begin
      n_err++; $display("FAIL b2b_empty: empty=%b, want 1", empty); end
  endtask

  task automatic test_underflow();
    n_vec++; if (err_underflow !== 1'b0) begin
      n_err++; $display("FAIL uf_initial: err=%b, want 0", err_underflow); end
    rd_en = 1'b1; step(); rd_en = 1'b0;
    n_vec++; if (err_underflow !== 1'b1 || count !== 3'd0) begin
      n_err++; $display("FAIL uf_set: err=%b count=%0d, want 1/0", err_underflow, count); end
    stream_in = 64'h55; tvalid_stream_in = 2'b11; step();
    stream_in = 64'h56; step();
    tvalid_stream_in = 2'b00;
    n_vec++; if (err_underflow !== 1'b1 || count !== 3'd2 || FIFO_out_tdata !== 64'h55) begin
      n_err++; $display("FAIL uf_sticky: err=%b count=%0d head=%h, want 1/2/55", err_underflow, count, FIFO_out_tdata); end
    flush = 1'b1; #1;
    n_vec++; if (tready_stream_in !== 1'b0) begin
      n_err++; $display("FAIL uf_flush_ready: ready=%b, want 0", tready_stream_in); end
    step(); flush = 1'b0;
    n_vec++; if (err_underflow !== 1'b0 || count !== 3'd0) begin
      n_err++; $display("FAIL uf_flush_clear: err=%b count=%0d, want 0/0", err_underflow, count); end
  endtask

  task automatic test_flush_precedence();
    tvalid_stream_in = 2'b11;
    for (int i = 0; i < 3; i++) begin
      stream_in = 64'hE0 + 64'(i); step();
    end
    n_vec++; if (count !== 3'd3 || almost_full !== 1'b1) begin
      n_err++; $display("FAIL fp_prefill: count=%0d af=%b, want 3/1", count, almost_full); end
    stream_in = 64'hEE; rd_en = 1'b1; flush = 1'b1; #1;
    n_vec++; if (tready_stream_in !== 1'b0) begin
      n_err++; $display("FAIL fp_ready: ready=%b, want 0", tready_stream_in); end
    step();
    flush = 1'b0; rd_en = 1'b0; tvalid_stream_in = 2'b00;
    n_vec++; if (count !== 3'd0 || empty !== 1'b1 || FIFO_out_tdata !== 64'h0 || FIFO_out_tvalid !== 2'b00) begin
      n_err++; $display("FAIL fp_cleared: count=%0d empty=%b data=%h mask=%b, want 0/1/0/00", count, empty, FIFO_out_tdata, FIFO_out_tvalid); end
    stream_in = 64'h77; tvalid_stream_in = 2'b01; step();
    tvalid_stream_in = 2'b00;
    n_vec++; if (count !== 3'd1 || FIFO_out_tdata !== 64'h77 || FIFO_out_tvalid !== 2'b01) begin
      n_err++; $display("FAIL fp_after: count=%0d data=%h mask=%b, want 1/77/01", count, FIFO_out_tdata, FIFO_out_tvalid); end
  endtask

  initial begin
    test_reset();
    test_fill_stall_drain();
    test_masks();
    test_back_to_back();
    test_underflow();
    test_flush_precedence();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
